// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: start/ready/done request bus for alu_multicycle
interface alu_multicycle_if #(parameter int WIDTH = 32);
  logic Start_i;
  logic [3:0] ALU_Operation_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic Ready_o;
  logic Done_o;
  logic [WIDTH-1:0] ALU_Result_o;
  logic Zero_o;
  modport master (output Start_i, ALU_Operation_i, A_i, B_i, input Ready_o, Done_o, ALU_Result_o, Zero_o);
  modport slave (input Start_i, ALU_Operation_i, A_i, B_i, output Ready_o, Done_o, ALU_Result_o, Zero_o);
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with iterative shift-add multiply and restoring divide
module alu_multicycle #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic reset,
  alu_multicycle_if.slave bus
);
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d, alu, mul_acc, rem_sub;
  logic [WIDTH:0] rem_sh;
  logic [SHW:0] cnt_q, cnt_d;
  logic zero_q, zero_d, ge, multi;
  logic [SHW-1:0] sh;
  always_comb begin
    sh = bus.B_i[SHW-1:0];
    case (bus.ALU_Operation_i)
      4'b0000: alu = bus.A_i + bus.B_i;
      4'b0001: alu = bus.A_i - bus.B_i;
      4'b0010: alu = bus.A_i ^ bus.B_i;
      4'b0011: alu = bus.A_i | bus.B_i;
      4'b0100: alu = bus.A_i & bus.B_i;
      4'b0101: alu = bus.A_i << sh;
      4'b0110: alu = $signed(bus.A_i) >>> sh;
      4'b0111: alu = bus.A_i >> sh;
      4'b1000: alu = WIDTH'($signed(bus.A_i) < $signed(bus.B_i));
      4'b1001: alu = bus.B_i << 12;
      4'b1010: alu = WIDTH'(bus.A_i < bus.B_i);
      default: alu = '0;
    endcase
  end
  always_comb begin
    multi = bus.ALU_Operation_i == OP_MUL || bus.ALU_Operation_i == OP_DIVU || bus.ALU_Operation_i == OP_REMU;
    mul_acc = acc_q + (b_q[0] ? a_q : '0);
    rem_sh = {acc_q, a_q[WIDTH-1]};
    ge = rem_sh >= {1'b0, b_q};
    rem_sub = rem_sh[WIDTH-1:0] - b_q;
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.Start_i && multi) begin
          op_d = bus.ALU_Operation_i;
          a_d = bus.A_i;
          b_d = bus.B_i;
          acc_d = '0;
          cnt_d = (SHW+1)'(WIDTH);
          state_d = RUN;
        end else if (bus.Start_i) begin
          res_d = alu;
          zero_d = alu == '0;
          state_d = DONE;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        acc_d = op_q == OP_MUL ? mul_acc : ge ? rem_sub : rem_sh[WIDTH-1:0];
        a_d = op_q == OP_MUL ? a_q << 1 : {a_q[WIDTH-2:0], ge};
        b_d = op_q == OP_MUL ? b_q >> 1 : b_q;
        if (cnt_q == 1) begin
          res_d = op_q == OP_DIVU ? a_d : acc_d;
          zero_d = res_d == '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      zero_q <= zero_d;
    end
  end
  assign bus.Ready_o = state_q == IDLE;
  assign bus.Done_o = state_q == DONE;
  assign bus.ALU_Result_o = res_q;
  assign bus.Zero_o = zero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vector table plus multi-cycle handshake sequences
module tb_alu_multicycle;
  typedef struct {
    string name;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t vecs [22];
  alu_multicycle_if #(.WIDTH(32)) bus ();
  alu_multicycle #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output logic [31:0] res, output logic z, output int lat);
    bus.Start_i = 1'b1;
    bus.ALU_Operation_i = op;
    bus.A_i = a;
    bus.B_i = b;
    @(posedge clk);
    #1;
    bus.Start_i = 1'b0;
    bus.ALU_Operation_i = 4'($urandom);
    bus.A_i = $urandom;
    bus.B_i = $urandom;
    lat = 1;
    while (!bus.Done_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.ALU_Result_o;
    z = bus.Zero_o;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] res;
    logic z;
    int lat, ready_low, dones;
    vecs = '{
      '{"add", 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1},
      '{"sub", 4'b0001, 32'h5, 32'h5, 32'h0, 1},
      '{"xor", 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1},
      '{"or", 4'b0011, 32'hF0, 32'h0F, 32'hFF, 1},
      '{"and", 4'b0100, 32'hF0F0, 32'hFF00, 32'hF000, 1},
      '{"sll", 4'b0101, 32'h1, 32'h24, 32'h10, 1},
      '{"sra", 4'b0110, 32'h80000000, 32'h21, 32'hC0000000, 1},
      '{"srl", 4'b0111, 32'h80000000, 32'h21, 32'h40000000, 1},
      '{"slt", 4'b1000, 32'hFFFFFFFF, 32'h1, 32'h1, 1},
      '{"sltu", 4'b1010, 32'hFFFFFFFF, 32'h1, 32'h0, 1},
      '{"lui", 4'b1001, 32'hDEAD, 32'h12345, 32'h12345000, 1},
      '{"mul", 4'b1011, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD, 33},
      '{"mul_wrap", 4'b1011, 32'h10000, 32'h10000, 32'h0, 33},
      '{"mul_dec", 4'b1011, 32'd12345, 32'd100, 32'h0012D644, 33},
      '{"divu", 4'b1100, 32'd100, 32'd7, 32'd14, 33},
      '{"remu", 4'b1101, 32'd100, 32'd7, 32'd2, 33},
      '{"divu0", 4'b1100, 32'd9, 32'd0, 32'hFFFFFFFF, 33},
      '{"remu0", 4'b1101, 32'd9, 32'd0, 32'd9, 33},
      '{"divu_big", 4'b1100, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33},
      '{"remu_big", 4'b1101, 32'hFFFFFFFF, 32'h10, 32'hF, 33},
      '{"op1110", 4'b1110, 32'hFFFF, 32'hFFFF, 32'h0, 1},
      '{"op1111", 4'b1111, 32'hFFFF, 32'hFFFF, 32'h0, 1}
    };
    bus.Start_i = 1'b0;
    bus.ALU_Operation_i = 4'b0;
    bus.A_i = '0;
    bus.B_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.Ready_o), 32'h1);
    chk("rst_done", 32'(bus.Done_o), 32'h0);
    chk("rst_result", bus.ALU_Result_o, 32'h0);
    chk("rst_zero", 32'(bus.Zero_o), 32'h1);
    reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
      chk({vecs[i].name, "_result"}, res, vecs[i].exp);
      chk({vecs[i].name, "_zero"}, 32'(z), 32'(vecs[i].exp == 32'h0));
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
    end
    run(4'b0000, 32'd2, 32'd3, res, z, lat);
    chk("pre_mul_add", res, 32'd5);
    bus.Start_i = 1'b1;
    bus.ALU_Operation_i = 4'b1011;
    bus.A_i = 32'hFFFFFFFF;
    bus.B_i = 32'h3;
    @(posedge clk);
    #1;
    bus.Start_i = 1'b0;
    ready_low = 0;
    dones = 0;
    res = '0;
    for (int c = 1; c <= 40; c++) begin
      if (!bus.Ready_o) ready_low++;
      if (bus.Done_o) begin
        dones++;
        res = bus.ALU_Result_o;
      end
      if (c == 5) chk("hold_mid_run", bus.ALU_Result_o, 32'd5);
      bus.Start_i = c >= 2 && c <= 20;
      bus.ALU_Operation_i = 4'b0000;
      bus.A_i = 32'h1;
      bus.B_i = 32'h1;
      @(posedge clk);
      #1;
    end
    bus.Start_i = 1'b0;
    chk("mul_ready_low", 32'(ready_low), 32'd33);
    chk("mul_done_count", 32'(dones), 32'd1);
    chk("mul_ignore_start", res, 32'hFFFFFFFD);
    bus.Start_i = 1'b1;
    bus.ALU_Operation_i = 4'b1100;
    bus.A_i = 32'd100;
    bus.B_i = 32'd7;
    @(posedge clk);
    #1;
    bus.Start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_ready", 32'(bus.Ready_o), 32'h1);
    chk("midrst_done", 32'(bus.Done_o), 32'h0);
    chk("midrst_result", bus.ALU_Result_o, 32'h0);
    chk("midrst_zero", 32'(bus.Zero_o), 32'h1);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.Done_o) dones++;
      @(posedge clk);
      #1;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    run(4'b0000, 32'd2, 32'd3, res, z, lat);
    chk("post_rst_add", res, 32'd5);
    chk("post_rst_latency", 32'(lat), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
